// File: rtl/clk_div_prog.sv
// Programmable integer clock divider with exact 50% duty for odd and even ratios.
// New ratios are staged as pending and take effect only on a period boundary.
module clk_div_prog #(
    parameter int W       = 8,
    parameter int DEF_DIV = 9
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic [W-1:0] div_val,
    input  logic         div_load,
    output logic         div_pend,
    output logic         div_err,
    output logic         clk_div,
    output logic         tick
);

    localparam logic [W-1:0] DEF_N = W'(DEF_DIV);
    localparam logic [W-1:0] ONE   = W'(1);

    logic [W-1:0] r_cnt;
    logic [W-1:0] r_n_act;
    logic [W-1:0] r_pend_val;
    logic         r_pend;
    logic         r_err;
    logic         r_run;
    logic         r_p;
    logic         r_n;
    logic         r_tick;

    logic [W-1:0] w_cnt_nxt;
    logic [W-1:0] w_n_nxt;
    logic [W-1:0] w_half;
    logic         w_bound;
    logic         w_load_ok;

    // A period boundary is any edge whose next count is 0: wrap, restart after idle, or idle.
    always_comb begin
        w_load_ok = div_load && (div_val > ONE);
        w_cnt_nxt = '0;
        if (en && r_run && (r_cnt != (r_n_act - ONE))) begin
            w_cnt_nxt = r_cnt + ONE;
        end
        w_bound = (w_cnt_nxt == '0);
        w_n_nxt = (w_bound && r_pend) ? r_pend_val : r_n_act;
        w_half  = w_n_nxt >> 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt      <= '0;
            r_n_act    <= DEF_N;
            r_pend_val <= '0;
            r_pend     <= 1'b0;
            r_err      <= 1'b0;
            r_run      <= 1'b0;
            r_p        <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_n_act <= w_n_nxt;
            r_run   <= en;
            r_err   <= div_load && !w_load_ok;
            r_p     <= en && (w_cnt_nxt < w_half);
            r_tick  <= en && w_bound;
            // A load on the boundary edge is staged for the following boundary.
            if (w_load_ok) begin
                r_pend_val <= div_val;
                r_pend     <= 1'b1;
            end else if (w_bound) begin
                r_pend <= 1'b0;
            end
        end
    end

    // Half-cycle extension of the high phase, only meaningful for odd ratios.
    always_ff @(negedge clk) begin
        if (rst) begin
            r_n <= 1'b0;
        end else begin
            r_n <= r_p & r_n_act[0];
        end
    end

    assign clk_div  = r_p | r_n;
    assign tick     = r_tick;
    assign div_pend = r_pend;
    assign div_err  = r_err;

endmodule

// File: tb/tb_clk_div_prog.sv
// Self-checking bench for clk_div_prog: directed scenarios followed by random traffic,
// compared per half-cycle against a period-position reference model.
module tb_clk_div_prog;

    localparam int W       = 8;
    localparam int DEF_DIV = 9;

    logic         clk = 1'b0;
    logic         rst;
    logic         en;
    logic [W-1:0] div_val;
    logic         div_load;
    logic         div_pend;
    logic         div_err;
    logic         clk_div;
    logic         tick;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // {skip_hi_phase, tick, div_pend, div_err, clk_hi_phase, clk_lo_phase}
    logic [5:0] exp_q[$];

    // Reference state: position k inside an N-cycle period, pending ratio, running flag.
    int m_k    = 0;
    int m_n    = DEF_DIV;
    int m_pval = 0;
    bit m_pend = 1'b0;
    bit m_err  = 1'b0;
    bit m_run  = 1'b0;

    clk_div_prog #(.W(W), .DEF_DIV(DEF_DIV)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .div_val  (div_val),
        .div_load (div_load),
        .div_pend (div_pend),
        .div_err  (div_err),
        .clk_div  (clk_div),
        .tick     (tick)
    );

    always #5 clk = ~clk;

    // clk_div is high for the first N of the 2N half-cycles of each period.
    task automatic model_edge(input bit r, input bit e, input bit l, input int v);
        bit skip;
        bit bnd;
        skip = 1'b0;
        if (r) begin
            m_k    = 0;
            m_n    = DEF_DIV;
            m_pend = 1'b0;
            m_err  = 1'b0;
            m_run  = 1'b0;
            skip   = 1'b1;
        end else begin
            skip  = m_run && !e;
            m_err = l && (v < 2);
            if (!e || !m_run || (m_k == m_n - 1)) begin
                m_k = 0;
                bnd = 1'b1;
            end else begin
                m_k = m_k + 1;
                bnd = 1'b0;
            end
            if (bnd && m_pend) begin
                m_n    = m_pval;
                m_pend = 1'b0;
            end
            if (l && (v >= 2)) begin
                m_pval = v;
                m_pend = 1'b1;
            end
            m_run = e;
        end
        exp_q.push_back({skip,
                         m_run && (m_k == 0),
                         m_pend,
                         m_err,
                         m_run && (2 * m_k < m_n),
                         m_run && (2 * m_k + 1 < m_n)});
    endtask

    task automatic chk(input string tag, input logic obs, input logic expv);
        n_checks++;
        assert (obs === expv) else begin
            n_errors++;
            $error("FAIL %s cycle %0d: observed %b expected %b (N=%0d k=%0d)",
                   tag, cyc, obs, expv, m_n, m_k);
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic l, input logic [W-1:0] v);
        logic [5:0] ex;
        rst      = r;
        en       = e;
        div_load = l;
        div_val  = v;
        @(posedge clk);
        cyc++;
        model_edge(r, e, l, int'(v));
        #1;
        ex = exp_q.pop_front();
        chk("tick", tick, ex[4]);
        chk("div_pend", div_pend, ex[3]);
        chk("div_err", div_err, ex[2]);
        if (!ex[5]) chk("clk_div_first_half", clk_div, ex[1]);
        @(negedge clk);
        #1;
        chk("clk_div_second_half", clk_div, ex[0]);
    endtask

    task automatic run(input int n, input logic e);
        for (int i = 0; i < n; i++) cycle(1'b0, e, 1'b0, '0);
    endtask

    task automatic load(input logic [W-1:0] v);
        cycle(1'b0, 1'b1, 1'b1, v);
    endtask

    initial begin
        logic [W-1:0] rv;
        int           sel;

        // Reset state, then default ratio 9.
        cycle(1'b1, 1'b0, 1'b0, '0);
        cycle(1'b1, 1'b1, 1'b1, 8'd4);
        run(30, 1'b1);

        // Mid-period load of 6.
        run(3, 1'b1);
        load(8'd6);
        run(25, 1'b1);

        // Illegal ratios 1 and 0.
        load(8'd1);
        run(3, 1'b1);
        load(8'd0);
        run(15, 1'b1);

        // Last writer wins: 5 then 7 before the wrap.
        for (int i = 0; i < 12 && m_k != 1; i++) run(1, 1'b1);
        load(8'd5);
        load(8'd7);
        run(25, 1'b1);

        // Load on the wrap edge goes pending until the following wrap.
        for (int i = 0; i < 12 && m_k != m_n - 2; i++) run(1, 1'b1);
        run(1, 1'b1);
        load(8'd4);
        run(20, 1'b1);

        // N=3, enable dropped for 4 cycles during the high phase.
        load(8'd3);
        for (int i = 0; i < 20 && !(m_n == 3 && m_k == 0); i++) run(1, 1'b1);
        run(4, 1'b0);
        run(12, 1'b1);

        // Load while idle applies on the next edge.
        run(2, 1'b0);
        cycle(1'b0, 1'b0, 1'b1, 8'd5);
        run(2, 1'b0);
        run(12, 1'b1);

        // Reset during a pending load of 4 restores the default ratio.
        run(2, 1'b1);
        load(8'd4);
        cycle(1'b1, 1'b1, 1'b0, '0);
        run(30, 1'b1);

        // Maximum ratio 255.
        load(8'd255);
        run(530, 1'b1);
        cycle(1'b1, 1'b1, 1'b0, '0);

        // Random traffic.
        for (int i = 0; i < 900; i++) begin
            sel = int'($urandom_range(0, 99));
            rv  = W'($urandom_range(0, 13));
            if (sel < 1) begin
                cycle(1'b1, $urandom_range(0, 1) != 0, 1'b1, rv);
            end else if (sel < 9) begin
                cycle(1'b0, $urandom_range(0, 9) != 0, 1'b1, rv);
            end else begin
                cycle(1'b0, $urandom_range(0, 11) != 0, 1'b0, '0);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
